seg7_status_ctrl: RTL and testbench

SEG7_STATUS_CTRL -- requirements
Module: seg7_status_ctrl

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_hex_decode.sv | 30 +++
 rtl/seg7_status_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_status_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment status controller.
// Mode encoding matches the iMODE port value.
package seg7_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        VALUE = 2'd1,
        LAMP  = 2'd2,
        BLANK = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_ALL_ON  = 7'h00;
    localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment pattern, bit order gfedcba.
// Purely combinational; one instance per digit.
module seg7_hex_decode (
    input  logic [3:0] iNIB,
    output logic [6:0] oSEG
);

    always_comb begin
        oSEG = 7'h7F;
        unique case (iNIB)
            4'h0: oSEG = 7'h40;
            4'h1: oSEG = 7'h79;
            4'h2: oSEG = 7'h24;
            4'h3: oSEG = 7'h30;
            4'h4: oSEG = 7'h19;
            4'h5: oSEG = 7'h12;
            4'h6: oSEG = 7'h02;
            4'h7: oSEG = 7'h78;
            4'h8: oSEG = 7'h00;
            4'h9: oSEG = 7'h10;
            4'hA: oSEG = 7'h08;
            4'hB: oSEG = 7'h03;
            4'hC: oSEG = 7'h46;
            4'hD: oSEG = 7'h21;
            4'hE: oSEG = 7'h06;
            4'hF: oSEG = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seg7_status_ctrl.sv
// 7-segment and status-LED controller with prescaler, free-run count and PWM.
// Optional digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_status_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_LEDS   = 10,
    parameter int PRESCALE   = 16777216,
    parameter int PWM_BITS   = 4
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [1:0]              iMODE,
    input  logic [4*NUM_DIGITS-1:0] iVALUE,
    input  logic                    iVALUE_VALID,
    input  logic [NUM_LEDS-1:0]     iLED_MASK,
    input  logic [PWM_BITS-1:0]     iBRIGHT,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
`endif
    output logic [7*NUM_DIGITS-1:0] oSEG,
    output logic [NUM_LEDS-1:0]     oLEDR,
    output logic                    oTICK
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]             pre_q;
    logic                      tick_q;
    logic [3:0]                cnt_q;
    logic [PWM_BITS-1:0]       pwm_q;
    logic [4*NUM_DIGITS-1:0]   val_q;
    logic [7*NUM_DIGITS-1:0]   seg_q, seg_d;
    logic [NUM_LEDS-1:0]       led_q, led_d;
    logic [7*NUM_DIGITS-1:0]   dec_w;
    logic [NUM_LEDS-1:0]       free_pat_w;
    logic                      wrap_w;
    logic                      pwm_on_w;
    mode_e                     mode_w;
`ifdef SEG7_BLINK_EN
    logic                      phase_q;
`endif

    assign mode_w   = mode_e'(iMODE);
    assign wrap_w   = (pre_q == PW'(PRESCALE - 1));
    // All-ones brightness forces full duty; the counter alone would top out one short.
    assign pwm_on_w = (&iBRIGHT) || (pwm_q < iBRIGHT);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
            pwm_q  <= '0;
            val_q  <= '0;
            seg_q  <= {NUM_DIGITS{SEG_ALL_OFF}};
            led_q  <= '0;
        end else begin
            pre_q  <= wrap_w ? '0 : pre_q + PW'(1);
            tick_q <= wrap_w;
            cnt_q  <= cnt_q + 4'(wrap_w);
            pwm_q  <= pwm_q + PWM_BITS'(1);
            if (iVALUE_VALID)
                val_q <= iVALUE;
            seg_q  <= seg_d;
            led_q  <= led_d;
        end
    end

`ifdef SEG7_BLINK_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            phase_q <= 1'b0;
        else if (wrap_w)
            phase_q <= ~phase_q;
    end
`endif

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        logic [3:0] nib_w;
        assign nib_w = (mode_w == FREE) ? cnt_q : val_q[4*d +: 4];
        seg7_hex_decode u_dec (
            .iNIB (nib_w),
            .oSEG (dec_w[7*d +: 7])
        );
    end

    always_comb begin
        free_pat_w = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            free_pat_w[i] = cnt_q[i % 2];
    end

    always_comb begin
        seg_d = {NUM_DIGITS{SEG_ALL_OFF}};
        led_d = '0;
        unique case (mode_w)
            FREE: begin
                seg_d = dec_w;
                led_d = pwm_on_w ? (free_pat_w & iLED_MASK) : '0;
            end
            VALUE: begin
                seg_d = dec_w;
                led_d = pwm_on_w ? iLED_MASK : '0;
            end
            LAMP: begin
                seg_d = {NUM_DIGITS{SEG_ALL_ON}};
                led_d = '1;
            end
            BLANK: begin
                seg_d = {NUM_DIGITS{SEG_ALL_OFF}};
                led_d = '0;
            end
        endcase
`ifdef SEG7_BLINK_EN
        if ((mode_w == FREE || mode_w == VALUE) && phase_q) begin
            for (int d = 0; d < NUM_DIGITS; d++)
                if (iBLINK_MASK[d])
                    seg_d[7*d +: 7] = SEG_ALL_OFF;
        end
`endif
    end

    assign oSEG  = seg_q;
    assign oLEDR = led_q;
    assign oTICK = tick_q;

endmodule

// File: tb/tb_seg7_status_ctrl.sv
// Directed bench for seg7_status_ctrl with PRESCALE=4.
// Build with SEG7_BLINK_EN defined to also exercise digit blinking.
module tb_seg7_status_ctrl;

    localparam int ND = 6;
    localparam int NL = 10;
    localparam int PS = 4;
    localparam int PB = 4;

    logic            iCLK = 1'b0;
    logic            iRST_N;
    logic [1:0]      iMODE;
    logic [4*ND-1:0] iVALUE;
    logic            iVALUE_VALID;
    logic [NL-1:0]   iLED_MASK;
    logic [PB-1:0]   iBRIGHT;
`ifdef SEG7_BLINK_EN
    logic [ND-1:0]   iBLINK_MASK;
`endif
    logic [7*ND-1:0] oSEG;
    logic [NL-1:0]   oLEDR;
    logic            oTICK;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_status_ctrl #(
        .NUM_DIGITS (ND),
        .NUM_LEDS   (NL),
        .PRESCALE   (PS),
        .PWM_BITS   (PB)
    ) dut (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .iMODE        (iMODE),
        .iVALUE       (iVALUE),
        .iVALUE_VALID (iVALUE_VALID),
        .iLED_MASK    (iLED_MASK),
        .iBRIGHT      (iBRIGHT),
`ifdef SEG7_BLINK_EN
        .iBLINK_MASK  (iBLINK_MASK),
`endif
        .oSEG         (oSEG),
        .oLEDR        (oLEDR),
        .oTICK        (oTICK)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic test_reset();
        iRST_N = 1'b0;
        iMODE = 2'd0;
        iVALUE = '0;
        iVALUE_VALID = 1'b0;
        iLED_MASK = 10'b1111100000;
        iBRIGHT = 4'hF;
`ifdef SEG7_BLINK_EN
        iBLINK_MASK = '0;
`endif
        repeat (3) @(negedge iCLK);
        checks++;
        if (oSEG !== {ND{7'h7F}}) begin
            errors++;
            $display("FAIL reset_seg got %h want %h", oSEG, {ND{7'h7F}});
        end
        checks++;
        if (oLEDR !== '0 || oTICK !== 1'b0) begin
            errors++;
            $display("FAIL reset_led_tick got %b/%b want 0/0", oLEDR, oTICK);
        end
        iRST_N = 1'b1;
    endtask

    // FREE mode from reset release: ticks at cycles 4,8,..; count wraps after 16 ticks.
    task automatic test_free();
        int c;
        logic [NL-1:0] pat;
        for (int n = 0; n < 72; n++) begin
            @(negedge iCLK);
            checks++;
            if (oTICK !== ((cyc % PS) == 0)) begin
                errors++;
                $display("FAIL free_tick cyc=%0d got %b want %b", cyc, oTICK, (cyc % PS) == 0);
            end
            c = ((cyc - 1) / PS) % 16;
            checks++;
            if (oSEG[6:0] !== hex_tab[c] || oSEG[7*5 +: 7] !== hex_tab[c]) begin
                errors++;
                $display("FAIL free_seg cyc=%0d got %h want digit %h", cyc, oSEG, hex_tab[c]);
            end
            for (int i = 0; i < NL; i++) pat[i] = c[i % 2];
            checks++;
            if (oLEDR !== (pat & iLED_MASK)) begin
                errors++;
                $display("FAIL free_led cyc=%0d got %b want %b", cyc, oLEDR, pat & iLED_MASK);
            end
        end
    endtask

    task automatic test_value();
        iMODE = 2'd1;
        iLED_MASK = 10'b1010110011;
        iVALUE = 24'h012345;
        iVALUE_VALID = 1'b1;
        @(negedge iCLK);
        iVALUE_VALID = 1'b0;
        iVALUE = 24'hFFFFFF;
        checks++;
        if (oSEG[6:0] !== 7'h40) begin
            errors++;
            $display("FAIL value_early got %h want 40", oSEG[6:0]);
        end
        @(negedge iCLK);
        checks++;
        if (oSEG[6:0] !== 7'h12 || oSEG[7*5 +: 7] !== 7'h40) begin
            errors++;
            $display("FAIL value_seg got d0=%h d5=%h want 12/40", oSEG[6:0], oSEG[7*5 +: 7]);
        end
        checks++;
        if (oSEG[7*2 +: 7] !== 7'h30) begin
            errors++;
            $display("FAIL value_d2 got %h want 30", oSEG[7*2 +: 7]);
        end
        checks++;
        if (oLEDR !== 10'b1010110011) begin
            errors++;
            $display("FAIL value_led got %b want 1010110011", oLEDR);
        end
    endtask

    task automatic count_on(input logic [PB-1:0] b, input int want);
        int on0, on9;
        iBRIGHT = b;
        repeat (2) @(negedge iCLK);
        on0 = 0;
        on9 = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge iCLK);
            on0 += int'(oLEDR[0]);
            on9 += int'(oLEDR[9]);
        end
        checks++;
        if (on0 !== want || on9 !== want) begin
            errors++;
            $display("FAIL pwm_b%0d got %0d/%0d want %0d", b, on0, on9, want);
        end
    endtask

    task automatic test_pwm();
        iMODE = 2'd1;
        iLED_MASK = '1;
        count_on(4'd4, 4);
        count_on(4'd15, 16);
        count_on(4'd0, 0);
        count_on(4'd9, 9);
    endtask

    task automatic test_lamp_blank();
        iBRIGHT = 4'd0;
        iLED_MASK = '0;
        iMODE = 2'd2;
        @(negedge iCLK);
        checks++;
        if (oSEG !== '0 || oLEDR !== '1) begin
            errors++;
            $display("FAIL lamp got %h/%b want 0/all1", oSEG, oLEDR);
        end
        checks++;
        if (oTICK !== ((cyc % PS) == 0)) begin
            errors++;
            $display("FAIL lamp_tick cyc=%0d got %b", cyc, oTICK);
        end
        iMODE = 2'd3;
        @(negedge iCLK);
        checks++;
        if (oSEG !== {ND{7'h7F}} || oLEDR !== '0) begin
            errors++;
            $display("FAIL blank got %h/%b want all1/0", oSEG, oLEDR);
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge iCLK);
            checks++;
            if (oTICK !== ((cyc % PS) == 0)) begin
                errors++;
                $display("FAIL blank_tick cyc=%0d got %b", cyc, oTICK);
            end
        end
    endtask

    // Strobe and mode change in the same cycle must both take effect.
    task automatic test_back_to_back();
        iMODE = 2'd2;
        @(negedge iCLK);
        iMODE = 2'd1;
        iBRIGHT = 4'hF;
        iLED_MASK = '1;
        iVALUE = 24'hABCDEF;
        iVALUE_VALID = 1'b1;
        @(negedge iCLK);
        iVALUE_VALID = 1'b0;
        checks++;
        if (oSEG[6:0] !== 7'h12) begin
            errors++;
            $display("FAIL b2b_mode got %h want 12", oSEG[6:0]);
        end
        @(negedge iCLK);
        checks++;
        if (oSEG[6:0] !== 7'h0E || oSEG[7*5 +: 7] !== 7'h08) begin
            errors++;
            $display("FAIL b2b_value got d0=%h d5=%h want 0E/08", oSEG[6:0], oSEG[7*5 +: 7]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        iMODE = 2'd2;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while ((cyc % PS) != 2 && n < 10);
        iRST_N = 1'b0;
        #1;
        checks++;
        if (oSEG !== {ND{7'h7F}} || oLEDR !== '0 || oTICK !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got %h/%b/%b", oSEG, oLEDR, oTICK);
        end
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (oTICK !== 1'b1 && n < 20);
        checks++;
        if (n != PS) begin
            errors++;
            $display("FAIL rstmid_first_tick got %0d cycles want %0d", n, PS);
        end
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink();
        int ph;
        iMODE = 2'd1;
        iVALUE = 24'h012345;
        iVALUE_VALID = 1'b1;
        @(negedge iCLK);
        iVALUE_VALID = 1'b0;
        iBLINK_MASK = 6'b000001;
        @(negedge iCLK);
        for (int n = 0; n < 24; n++) begin
            @(negedge iCLK);
            ph = ((cyc - 1) / PS) % 2;
            checks++;
            if (oSEG[6:0] !== (ph ? 7'h7F : 7'h12)) begin
                errors++;
                $display("FAIL blink_d0 cyc=%0d got %h", cyc, oSEG[6:0]);
            end
            checks++;
            if (oSEG[7 +: 7] !== 7'h19) begin
                errors++;
                $display("FAIL blink_d1 cyc=%0d got %h want 19", cyc, oSEG[7 +: 7]);
            end
        end
        iBLINK_MASK = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_free();
        test_value();
        test_pwm();
        test_lamp_blank();
        test_back_to_back();
        test_reset_mid();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
